cordic_issue_scheduler: RTL and testbench
=========================================

# cordic_issue_scheduler

Issue controller that sits ahead of the HCORDIC input multiplexer and owns the single iteration datapath. It buffers instructions arriving from fetch in a small FIFO and launches one instruction at a time with a `load` pulse. It counts iterations as `ALU_done` returns, retires the instruction on convergence, and, when the watchdog is compiled in, forces retirement after a bounded number of iterations.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.
- `MAX_ITER`, 32: watchdog iteration limit; range 2 to 63.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `fetch_valid` in 1: fetch presents an instruction.
- `fetch_tag` in 8: instruction tag.
- `fetch_mode` in 2: mode field (01 circular, 00 linear, 11 hyperbolic).
- `fetch_operation` in 1: 1 = rotation, 0 = vectoring.
- `fetch_ready` out 1: FIFO not full; combinational from the count.
- `ALU_done` in 1: datapath finished one iteration.
- `converge` in 1: datapath result met its convergence test; sampled only when `ALU_done`=1.
- `load` out 1: one-cycle launch pulse to the input mux.
- `load_tag` out 8, `load_mode` out 2, `load_operation` out 1: FIFO head fields, valid while `load`=1.
- `force_converge` out 1: one-cycle pulse telling the mux to divert the current result to scaling.
- `retire_valid` out 1, `retire_tag` out 8, `retire_timeout` out 1: retirement report.
- `iter_count` out 6: iterations completed for the in-flight instruction.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `busy` out 1: state is not IDLE.
- `protocol_err` out 1: sticky error flag.

## Operation
- FIFO:
  - A push happens when `fetch_valid` & `fetch_ready`.
  - A pop happens on the edge that leaves ISSUE.
  - A push and a pop in the same cycle leave the count unchanged.
  - When full, `fetch_ready`=0 even during a pop cycle, so a full FIFO never accepts.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, RUN, RETIRE.
  - IDLE: go to ISSUE if `fifo_count`≠0.
  - ISSUE: `load`=1 and `load_*` = head fields. Pop the head, clear `iter_count`, go to RUN.
  - RUN, on `ALU_done` with `converge`=1: go to RETIRE with `retire_timeout`=0. Do not increment `iter_count`.
  - RUN, on `ALU_done` with `converge`=0: increment `iter_count`.
  - RUN watchdog: if `converge`=0 and `iter_count`=MAX_ITER-1, pulse `force_converge` in the next cycle and go to RETIRE with `retire_timeout`=1.
  - RETIRE: `retire_valid`=1 for one cycle and `retire_tag` = tag of the launched instruction. Go to ISSUE if the FIFO is non-empty, else to IDLE.
- `iter_count` saturates at 63.
- `ALU_done` outside RUN is ignored for control and sets `protocol_err`. The flag clears only on `reset`.
- Reset mid-operation:
  - FIFO is emptied and state goes to IDLE.
  - The in-flight instruction is dropped; no `retire_valid`.

## Timing
- Reset values:
  - `load`, `force_converge`, `retire_valid`, `retire_timeout`, `busy`, `protocol_err`: 0.
  - `iter_count`, `fifo_count`, `retire_tag`, `load_*`: 0.
  - `fetch_ready`: 1.
- Push to launch:
  - A push accepted at edge k while IDLE with an empty FIFO gives `load`=1 in the cycle after edge k+1.
  - This is a 2-cycle latency; no same-cycle bypass.
- `load` and `force_converge` are single-cycle pulses decoded from registered state.
- Convergence to retire:
  - `ALU_done`&`converge` at edge m gives `retire_valid`=1 in the cycle after m.
  - The next `load` follows in the cycle after m+1 when the FIFO is non-empty.
- Throughput: one instruction per (iterations + 3) cycles.
- `fetch_ready` reflects the count after the previous edge.

## Configuration
- `SCHED_TIMEOUT_EN` defined: the MAX_ITER watchdog is active as described.
- `SCHED_TIMEOUT_EN` undefined:
  - `force_converge` and `retire_timeout` are tied to 0.
  - RUN leaves only on `converge`; `iter_count` still counts and saturates.

## Test plan
- Basic launch: reset, push tag 0x11 (mode 01, rotation), then `ALU_done` with `converge`=0 three times and once with `converge`=1. Required: `load` 2 cycles after push, `iter_count`=3, `retire_valid` with tag 0x11 and `retire_timeout`=0.
- FIFO full: push 5 tags while the first is RUNning. Required: `fetch_ready`=0 after the 4th accepted push and the 5th is held. Retiring the first lets the 5th be accepted. Issue order is FIFO order with no loss.
- Watchdog with macro defined: MAX_ITER=32, never assert `converge`. Required: `force_converge` pulse after the 32nd `ALU_done`, then `retire_timeout`=1. Without the macro: no retirement after 40 iterations and `iter_count`=40.
- Back-to-back: 2 queued instructions. Required: `load` for the second is exactly 2 cycles after the first's convergence edge, and IDLE is never entered.
- Reset mid-RUN: assert `reset` at iteration 5 with 2 entries queued. Required: no `retire_valid`, `fifo_count`=0, `busy`=0, `fetch_ready`=1 on the next cycle.
- Stray `ALU_done` in IDLE: required `protocol_err`=1 and held until reset, with no state change.

Source files
------------

// File: rtl/cordic_issue_scheduler.sv
// Issue controller for the HCORDIC iteration datapath: instruction FIFO, launch/retire FSM, iteration counter.
// Define SCHED_TIMEOUT_EN to compile in the MAX_ITER watchdog (forced retirement with retire_timeout=1).
module cordic_issue_scheduler #(
  parameter int DEPTH    = 4,
  parameter int MAX_ITER = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_valid,
  input  logic [7:0]             fetch_tag,
  input  logic [1:0]             fetch_mode,
  input  logic                   fetch_operation,
  output logic                   fetch_ready,
  input  logic                   ALU_done,
  input  logic                   converge,
  output logic                   load,
  output logic [7:0]             load_tag,
  output logic [1:0]             load_mode,
  output logic                   load_operation,
  output logic                   force_converge,
  output logic                   retire_valid,
  output logic [7:0]             retire_tag,
  output logic                   retire_timeout,
  output logic [5:0]             iter_count,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   protocol_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef SCHED_TIMEOUT_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif
  localparam logic [5:0]    ITER_LIMIT = 6'(MAX_ITER - 1);
  localparam logic [5:0]    ITER_SAT   = 6'd63;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RUN    = 2'd2,
    S_RETIRE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [5:0]    r_iter;
  logic [7:0]    r_inflight_tag;
  logic          r_timeout;
  logic          r_err;
  logic          w_push;
  logic          w_pop;
  logic          w_in_run;
  logic          w_done_ok;
  logic          w_wd_fire;
  logic [10:0]   w_head;

  // A full FIFO refuses fetch even while ISSUE is popping the head.
  assign fetch_ready = (r_count != FULL_COUNT);
  assign w_push      = fetch_valid & fetch_ready;
  assign w_pop       = (r_state == S_ISSUE);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_in_run    = (r_state == S_RUN);
  assign w_done_ok   = w_in_run & ALU_done & converge;
  assign w_wd_fire   = WD_EN & w_in_run & ALU_done & ~converge & (r_iter == ITER_LIMIT);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {fetch_tag, fetch_mode, fetch_operation};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = (r_count != '0) ? S_ISSUE : S_IDLE;
      S_ISSUE:  w_next_state = S_RUN;
      S_RUN:    w_next_state = (w_done_ok | w_wd_fire) ? S_RETIRE : S_RUN;
      S_RETIRE: w_next_state = (r_count != '0) ? S_ISSUE : S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_iter         <= '0;
      r_inflight_tag <= '0;
      r_timeout      <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_pop) begin
        r_iter         <= '0;
        r_inflight_tag <= w_head[10:3];
        r_timeout      <= 1'b0;
      end else begin
        if (w_in_run & ALU_done & ~converge & (r_iter != ITER_SAT)) begin
          r_iter <= r_iter + 6'd1;
        end
        if (w_wd_fire) begin
          r_timeout <= 1'b1;
        end
      end
      // A completion with nothing in flight is a datapath protocol violation; sticky until reset.
      if (ALU_done & ~w_in_run) begin
        r_err <= 1'b1;
      end
    end
  end

  assign load           = (r_state == S_ISSUE);
  assign load_tag       = load ? w_head[10:3] : 8'd0;
  assign load_mode      = load ? w_head[2:1]  : 2'd0;
  assign load_operation = load ? w_head[0]    : 1'b0;
  assign retire_valid   = (r_state == S_RETIRE);
  assign retire_timeout = retire_valid & r_timeout;
  assign force_converge = retire_valid & r_timeout;
  assign retire_tag     = r_inflight_tag;
  assign iter_count     = r_iter;
  assign fifo_count     = r_count;
  assign busy           = (r_state != S_IDLE);
  assign protocol_err   = r_err;
endmodule

// File: tb/tb_cordic_issue_scheduler.sv
// Self-checking bench for cordic_issue_scheduler: random instructions scored against a FIFO-order queue model.
module tb_cordic_issue_scheduler;
  localparam int DEPTH    = 4;
  localparam int MAX_ITER = 32;

  typedef struct packed {
    logic [7:0] tag;
    logic [1:0] mode;
    logic       op;
  } instr_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_valid = 1'b0;
  logic [7:0] fetch_tag = 8'd0;
  logic [1:0] fetch_mode = 2'd0;
  logic       fetch_operation = 1'b0;
  logic       fetch_ready;
  logic       ALU_done = 1'b0;
  logic       converge = 1'b0;
  logic       load;
  logic [7:0] load_tag;
  logic [1:0] load_mode;
  logic       load_operation;
  logic       force_converge;
  logic       retire_valid;
  logic [7:0] retire_tag;
  logic       retire_timeout;
  logic [5:0] iter_count;
  logic [2:0] fifo_count;
  logic       busy;
  logic       protocol_err;

  int     n_checks = 0;
  int     n_pass = 0;
  instr_t exp_q[$];
  int     m_count = 0;

  always #5 clock = ~clock;

  cordic_issue_scheduler #(.DEPTH(DEPTH), .MAX_ITER(MAX_ITER)) dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_tag(fetch_tag), .fetch_mode(fetch_mode),
    .fetch_operation(fetch_operation), .fetch_ready(fetch_ready),
    .ALU_done(ALU_done), .converge(converge),
    .load(load), .load_tag(load_tag), .load_mode(load_mode), .load_operation(load_operation),
    .force_converge(force_converge), .retire_valid(retire_valid), .retire_tag(retire_tag),
    .retire_timeout(retire_timeout), .iter_count(iter_count), .fifo_count(fifo_count),
    .busy(busy), .protocol_err(protocol_err)
  );

  function automatic instr_t rand_instr();
    instr_t r;
    r.tag = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 2))
      0:       r.mode = 2'b01;
      1:       r.mode = 2'b00;
      default: r.mode = 2'b11;
    endcase
    r.op = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic present(input instr_t i);
    fetch_valid = 1'b1;
    fetch_tag = i.tag;
    fetch_mode = i.mode;
    fetch_operation = i.op;
  endtask

  // One clock; the model accepts a push only when its own occupancy is below DEPTH, and the
  // bench drops fetch_valid once an instruction has been taken.
  task automatic step();
    logic acc;
    logic was_load;
    logic rst;
    acc = fetch_valid && (m_count < DEPTH) && !reset;
    was_load = (load === 1'b1) && !reset;
    rst = reset;
    @(posedge clock);
    #1;
    if (rst) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      if (acc) begin
        exp_q.push_back({fetch_tag, fetch_mode, fetch_operation});
        m_count++;
        fetch_valid = 1'b0;
      end
      if (was_load) m_count--;
    end
  endtask

  task automatic wait_load_check(output logic [7:0] tag);
    int w;
    instr_t e;
    w = 0;
    tag = 8'h00;
    while (load !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    n_checks++;
    if (load !== 1'b1) $display("FAIL load_wait got=%0b exp=1", load);
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL load_fields got=%0h exp=<none queued>", {load_tag, load_mode, load_operation});
    end else begin
      e = exp_q.pop_front();
      tag = e.tag;
      if ({load_tag, load_mode, load_operation} !== e)
        $display("FAIL load_fields got=%0h exp=%0h", {load_tag, load_mode, load_operation}, e);
      else n_pass++;
    end
  endtask

  // From the ISSUE cycle: n non-converging iterations, then a converging one; ends in the RETIRE cycle.
  task automatic run_iters(input logic [7:0] tag, input int n);
    step();
    ALU_done = 1'b1;
    converge = 1'b0;
    repeat (n) step();
    converge = 1'b1;
    step();
    ALU_done = 1'b0;
    converge = 1'b0;
    n_checks++;
    if ({retire_valid, retire_tag, retire_timeout, iter_count} !== {1'b1, tag, 1'b0, 6'(n)})
      $display("FAIL retire got=%0b/%0h/%0b/%0d exp=1/%0h/0/%0d",
               retire_valid, retire_tag, retire_timeout, iter_count, tag, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if ({load, force_converge, retire_valid, retire_timeout, busy, protocol_err} !== 6'b0)
      $display("FAIL reset_flags got=%06b exp=000000",
               {load, force_converge, retire_valid, retire_timeout, busy, protocol_err});
    else n_pass++;
    n_checks++;
    if ({iter_count, fifo_count, retire_tag, load_tag, load_mode, load_operation} !== 28'd0)
      $display("FAIL reset_values got=%0h exp=0",
               {iter_count, fifo_count, retire_tag, load_tag, load_mode, load_operation});
    else n_pass++;
    n_checks++;
    if (fetch_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", fetch_ready);
    else n_pass++;
  endtask

  task automatic test_basic_launch();
    instr_t i;
    logic [7:0] tag;
    i.tag = 8'h11;
    i.mode = 2'b01;
    i.op = 1'b1;
    present(i);
    step();
    n_checks++;
    if ({load, fifo_count} !== {1'b0, 3'd1}) $display("FAIL basic_push got=%0b/%0d exp=0/1", load, fifo_count);
    else n_pass++;
    step();
    n_checks++;
    if (load !== 1'b1) $display("FAIL basic_latency got=%0b exp=1", load);
    else n_pass++;
    wait_load_check(tag);
    n_checks++;
    if (load_tag !== 8'h11) $display("FAIL basic_tag got=%0h exp=11", load_tag);
    else n_pass++;
    run_iters(tag, 3);
    step();
    n_checks++;
    if ({busy, retire_valid} !== 2'b00) $display("FAIL basic_idle got=%02b exp=00", {busy, retire_valid});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] tag;
    present(rand_instr());
    step();
    present(rand_instr());
    step();
    wait_load_check(tag);
    run_iters(tag, $urandom_range(0, 6));
    n_checks++;
    if ({load, busy} !== 2'b01) $display("FAIL b2b_retire got=%02b exp=01", {load, busy});
    else n_pass++;
    step();
    n_checks++;
    if ({load, busy} !== 2'b11) $display("FAIL b2b_launch got=%02b exp=11", {load, busy});
    else n_pass++;
    wait_load_check(tag);
    run_iters(tag, $urandom_range(0, 6));
    step();
  endtask

  task automatic test_fifo_full();
    instr_t ins[5];
    logic [7:0] tag;
    int w;
    for (int k = 0; k < 5; k++) ins[k] = rand_instr();
    present(rand_instr());
    step();
    wait_load_check(tag);
    step();
    for (int k = 0; k < 4; k++) begin
      present(ins[k]);
      w = 0;
      while (fetch_valid && w < 8) begin
        step();
        w++;
      end
    end
    n_checks++;
    if ({fetch_ready, fifo_count} !== {1'b0, 3'(m_count)})
      $display("FAIL full_ready got=%0b/%0d exp=0/%0d", fetch_ready, fifo_count, m_count);
    else n_pass++;
    present(ins[4]);
    repeat (3) step();
    n_checks++;
    if ({fetch_ready, fifo_count} !== {1'b0, 3'd4})
      $display("FAIL full_hold got=%0b/%0d exp=0/4", fetch_ready, fifo_count);
    else n_pass++;
    ALU_done = 1'b1;
    converge = 1'b1;
    step();
    ALU_done = 1'b0;
    converge = 1'b0;
    n_checks++;
    if ({retire_valid, retire_tag} !== {1'b1, tag})
      $display("FAIL full_retire got=%0b/%0h exp=1/%0h", retire_valid, retire_tag, tag);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      wait_load_check(tag);
      run_iters(tag, $urandom_range(0, 5));
    end
    step();
    n_checks++;
    if ({busy, fifo_count} !== {1'b0, 3'd0}) $display("FAIL full_drain got=%0b/%0d exp=0/0", busy, fifo_count);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    logic [7:0] tag;
    logic seen;
    seen = 1'b0;
    present(rand_instr());
    step();
    wait_load_check(tag);
    step();
    ALU_done = 1'b1;
    converge = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    repeat (MAX_ITER - 1) begin
      step();
      if (retire_valid === 1'b1 || force_converge === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if ({seen, iter_count} !== {1'b0, 6'(MAX_ITER - 1)})
      $display("FAIL wd_pre got=%0b/%0d exp=0/%0d", seen, iter_count, MAX_ITER - 1);
    else n_pass++;
    step();
    ALU_done = 1'b0;
    n_checks++;
    if ({force_converge, retire_valid, retire_timeout, retire_tag} !== {3'b111, tag})
      $display("FAIL wd_fire got=%03b/%0h exp=111/%0h",
               {force_converge, retire_valid, retire_timeout}, retire_tag, tag);
    else n_pass++;
    step();
    n_checks++;
    if ({force_converge, retire_valid} !== 2'b00)
      $display("FAIL wd_pulse got=%02b exp=00", {force_converge, retire_valid});
    else n_pass++;
`else
    repeat (40) begin
      step();
      if (retire_valid === 1'b1 || force_converge === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if ({seen, busy, iter_count} !== {1'b0, 1'b1, 6'd40})
      $display("FAIL nowd_40 got=%0b/%0b/%0d exp=0/1/40", seen, busy, iter_count);
    else n_pass++;
    repeat (30) step();
    n_checks++;
    if (iter_count !== 6'd63) $display("FAIL nowd_sat got=%0d exp=63", iter_count);
    else n_pass++;
    converge = 1'b1;
    step();
    ALU_done = 1'b0;
    converge = 1'b0;
    n_checks++;
    if ({retire_valid, retire_timeout, force_converge, retire_tag} !== {3'b100, tag})
      $display("FAIL nowd_retire got=%03b/%0h exp=100/%0h",
               {retire_valid, retire_timeout, force_converge}, retire_tag, tag);
    else n_pass++;
    step();
`endif
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] tag;
    logic seen;
    seen = 1'b0;
    present(rand_instr());
    step();
    wait_load_check(tag);
    step();
    ALU_done = 1'b1;
    converge = 1'b0;
    present(rand_instr());
    step();
    present(rand_instr());
    step();
    repeat (3) step();
    ALU_done = 1'b0;
    n_checks++;
    if ({iter_count, fifo_count} !== {6'd5, 3'(m_count)})
      $display("FAIL mid_pre got=%0d/%0d exp=5/%0d", iter_count, fifo_count, m_count);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({retire_valid, fifo_count, busy, fetch_ready, iter_count} !== {1'b0, 3'd0, 1'b0, 1'b1, 6'd0})
      $display("FAIL mid_reset got=%0b/%0d/%0b/%0b/%0d exp=0/0/0/1/0",
               retire_valid, fifo_count, busy, fetch_ready, iter_count);
    else n_pass++;
    repeat (4) begin
      step();
      if (retire_valid === 1'b1 || load === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL mid_quiet got=%0b exp=0", seen);
    else n_pass++;
  endtask

  task automatic test_protocol_err();
    logic [7:0] tag;
    ALU_done = 1'b1;
    step();
    ALU_done = 1'b0;
    n_checks++;
    if ({protocol_err, busy, iter_count, fifo_count} !== {1'b1, 1'b0, 6'd0, 3'd0})
      $display("FAIL perr_set got=%0b/%0b/%0d/%0d exp=1/0/0/0", protocol_err, busy, iter_count, fifo_count);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if ({protocol_err, busy} !== 2'b10) $display("FAIL perr_hold got=%02b exp=10", {protocol_err, busy});
    else n_pass++;
    present(rand_instr());
    step();
    wait_load_check(tag);
    run_iters(tag, 2);
    n_checks++;
    if (protocol_err !== 1'b1) $display("FAIL perr_sticky got=%0b exp=1", protocol_err);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (protocol_err !== 1'b0) $display("FAIL perr_clear got=%0b exp=0", protocol_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_launch();
    test_back_to_back();
    test_fifo_full();
    test_watchdog();
    test_reset_mid_run();
    test_protocol_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
